// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : Byte FIFO that feeds a downstream UART transmitter. Bytes    |
// |               are pushed by the host, held in a circular buffer and sent   |
// |               one at a time with a single-cycle transmit pulse, pacing on  |
// |               the UART's is_transmitting busy flag.                        |
// | Parameters  : DEPTH          - FIFO entries (power of two, 2..256)         |
// |               START_TIMEOUT  - cycles to wait for is_transmitting to rise  |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               wr_en, wr_data[7:0]      - push interface                    |
// |               full, empty, level       - occupancy                         |
// |               overflow                 - sticky, push dropped while full   |
// |               transmit, tx_byte[7:0]   - start pulse and byte to the UART  |
// |               is_transmitting          - UART busy flag                    |
// | Option      : define UART_TX_FIFO_CRLF_EN to follow every sent 8'h0A with  |
// |               an inserted 8'h0D.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    transmit,
  output logic [7:0]              tx_byte,
  input  logic                    is_transmitting
);

  localparam int AW = $clog2(DEPTH);
  // Timeout counter only needs to reach START_TIMEOUT-1.
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic [7:0]    r_tx_byte;
  logic [TW-1:0] r_tmo_cnt;
  logic          w_push;
  logic          w_pop;
  logic          w_load_cr;
  logic          w_crlf_pend;

  assign full     = (r_level == LVL_FULL);
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign overflow = r_overflow;
  assign transmit = (r_state == LOAD);
  assign tx_byte  = r_tx_byte;

  // A push is judged against the current full flag, so a pop in the same
  // cycle never rescues a push made while full.
  assign w_push = wr_en && !full;

  // Next-state logic. The FIFO head is popped on the IDLE->LOAD edge so
  // tx_byte is already valid during the LOAD cycle that pulses transmit.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_cr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!is_transmitting) begin
          if (w_crlf_pend) begin
            w_load_cr   = 1'b1;
            w_state_nxt = LOAD;
          end else if (!empty) begin
            w_pop       = 1'b1;
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        w_state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (is_transmitting) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          // UART never acknowledged: give up on this byte.
          w_state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_TX_FIFO_CRLF_EN
  logic r_crlf_pend;
  logic w_byte_done;

  // A byte is finished either by the UART dropping busy or by the timeout.
  assign w_byte_done = ((r_state == WAIT_START) && !is_transmitting && (r_tmo_cnt == TMO_LAST)) ||
                       ((r_state == WAIT_DONE)  && !is_transmitting);

  // An inserted CR carries 8'h0D, so it can never re-arm the insertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crlf_pend <= 1'b0;
    end else if (w_load_cr) begin
      r_crlf_pend <= 1'b0;
    end else if (w_byte_done && (r_tx_byte == 8'h0A)) begin
      r_crlf_pend <= 1'b1;
    end
  end

  assign w_crlf_pend = r_crlf_pend;
`else
  assign w_crlf_pend = 1'b0;
`endif

  // Storage array is not reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_tmo_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_byte <= r_mem[r_rd_ptr];
      end else if (w_load_cr) begin
        r_tx_byte <= 8'h0D;
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end

      if (r_state == LOAD) begin
        r_tmo_cnt <= '0;
      end else if (r_state == WAIT_START) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_fifo                                              |
// | Description : Self-checking bench for uart_tx_fifo. A queue-based model    |
// |               tracks accepted bytes, occupancy and the expected transmit   |
// |               order; a small UART model drives is_transmitting.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int DEPTH         = 16;
  localparam int START_TIMEOUT = 15;
  localparam int LW            = $clog2(DEPTH) + 1;
`ifdef UART_TX_FIFO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  localparam int UART_NORMAL = 0;
  localparam int UART_LOW    = 1;
  localparam int UART_HIGH   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          is_transmitting = 1'b0;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          transmit;
  logic [7:0]    tx_byte;

  uart_tx_fifo #(
    .DEPTH         (DEPTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .full            (full),
    .empty           (empty),
    .level           (level),
    .overflow        (overflow),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, actual, actual, expected, expected, $time);
  endtask

  // ---------------- UART model ----------------
  int uart_mode = UART_NORMAL;
  int busy_len  = 10;
  bit busy_rand = 1'b0;
  int busy_cnt  = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) busy_cnt = 0;
    if (uart_mode == UART_HIGH) begin
      is_transmitting = 1'b1;
    end else if (uart_mode == UART_LOW) begin
      is_transmitting = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) begin
        is_transmitting = 1'b1;
        busy_cnt--;
      end else begin
        is_transmitting = 1'b0;
      end
      if (transmit === 1'b1) busy_cnt = busy_rand ? int'($urandom_range(1, 12)) : busy_len;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [7:0] b;
    bit         ins;
  } exp_t;

  exp_t       exp_q[$];
  int         m_level = 0;
  bit         m_ovf = 1'b0;
  bit         s_push = 1'b0;
  logic [7:0] s_data = 8'h00;
  int         cyc = 0;
  int         pulse_count = 0;
  int         last_pulse_cyc = 0;
  int         prev_pulse_cyc = 0;
  bit         prev_tx = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    s_push = wr_en && rst_n;
    s_data = wr_data;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      prev_tx = 1'b0;
    end else begin
      if (s_push) begin
        if (m_level < DEPTH) begin
          m_level++;
          exp_q.push_back('{b: s_data, ins: 1'b0});
          if (CRLF && s_data == 8'h0A) exp_q.push_back('{b: 8'h0D, ins: 1'b1});
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (transmit) begin
        exp_t e;
        pulse_count++;
        prev_pulse_cyc = last_pulse_cyc;
        last_pulse_cyc = cyc;
        check("pulse_single_cycle", int'(prev_tx), 0);
        check("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_byte_order", int'(tx_byte), int'(e.b));
          if (!e.ins) m_level--;
        end
      end
      prev_tx = transmit;
      check("level", int'(level), m_level);
      check("full", int'(full), int'(m_level == DEPTH));
      check("empty", int'(empty), int'(m_level == 0));
      check("overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         n;
    logic [7:0] d [17];
    int         mode_after;
    int         busy;
    int         mid_level;
    bit         mid_full;
    bit         ovf;
    int         pulses;
    int         end_level;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  task automatic set_vec(input int i, input int n, input int ma, input int bl, input int ml,
                         input bit mf, input bit ov, input int np, input int el);
    tbl[i].n = n;          tbl[i].mode_after = ma; tbl[i].busy = bl;
    tbl[i].mid_level = ml; tbl[i].mid_full = mf;   tbl[i].ovf = ov;
    tbl[i].pulses = np;    tbl[i].end_level = el;
  endtask

  initial begin
    int base;
    int j;
    logic [7:0] b;

    for (int i = 0; i < NV; i++) for (int k = 0; k < 17; k++) tbl[i].d[k] = 8'h00;
    // All vectors are pushed while the UART is busy, then the UART mode changes.
    set_vec(0,  2, UART_NORMAL, 10,  2, 1'b0, 1'b0, 2,                  0);
    tbl[0].d[0] = 8'h48; tbl[0].d[1] = 8'h69;
    set_vec(1,  1, UART_LOW,     1,  1, 1'b0, 1'b0, 1,                  0);
    tbl[1].d[0] = 8'h41;
    set_vec(2,  2, UART_NORMAL,  4,  2, 1'b0, 1'b0, CRLF ? 3 : 2,       0);
    tbl[2].d[0] = 8'h0A; tbl[2].d[1] = 8'h41;
    set_vec(3, 17, UART_NORMAL,  2, 16, 1'b1, 1'b1, 16,                 0);
    for (int k = 0; k < 17; k++) tbl[3].d[k] = 8'(8'h30 + k);
    set_vec(4,  3, UART_HIGH,    1,  3, 1'b0, 1'b0, 0,                  3);
    tbl[4].d[0] = 8'h61; tbl[4].d[1] = 8'h62; tbl[4].d[2] = 8'h63;
    set_vec(5, 16, UART_NORMAL,  1, 16, 1'b1, 1'b0, 16,                 0);
    for (int k = 0; k < 16; k++) tbl[5].d[k] = 8'(8'hA0 + k);
    set_vec(6,  2, UART_LOW,     1,  2, 1'b0, 1'b0, CRLF ? 4 : 2,       0);
    tbl[6].d[0] = 8'h0A; tbl[6].d[1] = 8'h0A;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_level", int'(level), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_transmit", int'(transmit), 0);
    check("reset_tx_byte", int'(tx_byte), 0);

    for (int i = 0; i < NV; i++) begin
      uart_mode = UART_HIGH;
      busy_rand = 1'b0;
      busy_len  = tbl[i].busy;
      do_reset();
      for (int k = 0; k < tbl[i].n; k++) push(tbl[i].d[k]);
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_mid_level", i), int'(level), tbl[i].mid_level);
      check($sformatf("tbl%0d_mid_full", i), int'(full), int'(tbl[i].mid_full));
      check($sformatf("tbl%0d_mid_overflow", i), int'(overflow), int'(tbl[i].ovf));
      base = pulse_count;
      uart_mode = tbl[i].mode_after;
      repeat (400) @(negedge clk);
      check($sformatf("tbl%0d_pulses", i), pulse_count - base, tbl[i].pulses);
      check($sformatf("tbl%0d_end_level", i), int'(level), tbl[i].end_level);
      check($sformatf("tbl%0d_end_empty", i), int'(empty), int'(tbl[i].end_level == 0));
      check($sformatf("tbl%0d_end_overflow", i), int'(overflow), int'(tbl[i].ovf));
    end

    // Latency: push edge, then IDLE->LOAD edge, then transmit visible.
    uart_mode = UART_NORMAL;
    busy_len  = 10;
    do_reset();
    @(negedge clk);
    push(8'h55);
    check("latency_one_cycle", int'(transmit), 0);
    @(negedge clk);
    check("latency_two_cycles", int'(transmit), 1);
    check("latency_tx_byte", int'(tx_byte), 8'h55);
    repeat (40) @(negedge clk);

    // Start timeout: stuck-low UART, spacing of back-to-back pulses, no retry.
    uart_mode = UART_LOW;
    do_reset();
    base = pulse_count;
    push(8'h41);
    push(8'h42);
    j = 0;
    while (pulse_count - base < 2 && j < 100) begin
      @(negedge clk);
      j++;
    end
    check("timeout_two_pulses", pulse_count - base, 2);
    check("timeout_spacing", last_pulse_cyc - prev_pulse_cyc, START_TIMEOUT + 2);
    repeat (40) @(negedge clk);
    check("timeout_no_retry", pulse_count - base, 2);
    check("timeout_level", int'(level), 0);

    // Reset while the second of three bytes is in WAIT_DONE.
    uart_mode = UART_NORMAL;
    busy_len  = 10;
    do_reset();
    base = pulse_count;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    j = 0;
    while (pulse_count - base < 2 && j < 200) begin
      @(negedge clk);
      j++;
    end
    check("rst_second_pulse", pulse_count - base, 2);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_level", int'(level), 0);
    check("rst_async_empty", int'(empty), 1);
    check("rst_async_full", int'(full), 0);
    check("rst_async_overflow", int'(overflow), 0);
    check("rst_async_transmit", int'(transmit), 0);
    check("rst_async_tx_byte", int'(tx_byte), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = pulse_count;
    repeat (60) @(negedge clk);
    check("rst_no_pulse_after", pulse_count - base, 0);

    // Pointer wrap: 40 bytes through the FIFO in bursts of 10.
    uart_mode = UART_NORMAL;
    busy_rand = 1'b1;
    do_reset();
    j = 0;
    for (int burst = 0; burst < 4; burst++) begin
      for (int k = 0; k < 10; k++) begin
        push(8'(j));
        j++;
      end
      wait_drain($sformatf("wrap_drain%0d", burst), 1000);
    end
    check("wrap_overflow", int'(overflow), 0);
    check("wrap_empty", int'(empty), 1);

    // Randomized traffic, overflow allowed.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 45) begin
        b = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
        wr_en   = 1'b1;
        wr_data = b;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_drain("rand_drain", 4000);
    check("rand_empty", int'(empty), 1);
    check("rand_level", int'(level), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter START_TIMEOUT, default 15, max cycles waited for is_transmitting to rise after a transmit pulse.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  push request, one byte per cycle.
REQ-006 wr_data  input  8  byte to push.
REQ-007 full  output  1  high when level == DEPTH.
REQ-008 empty  output  1  high when level == 0.
REQ-009 level  output  clog2(DEPTH)+1  current stored byte count.
REQ-010 overflow  output  1  sticky; set by a push dropped while full.
REQ-011 transmit  output  1  one-cycle start pulse to the downstream uart.
REQ-012 tx_byte  output  8  byte for the uart; stable from the transmit pulse until return to IDLE.
REQ-013 is_transmitting  input  1  uart busy flag.

Function
REQ-014 Storage SHALL be a circular buffer; read/write pointers wrap modulo DEPTH.
REQ-015 Push with wr_en high and full low SHALL store wr_data; level increments next cycle.
REQ-016 Push while full SHALL be dropped, data unchanged, overflow set; this holds even if a pop occurs in the same cycle.
REQ-017 Simultaneous accepted push and pop SHALL leave level unchanged.
REQ-018 FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
REQ-019 IDLE -> LOAD when empty low and is_transmitting low.
REQ-020 LOAD (one cycle) SHALL pop head into tx_byte, decrement level, and assert transmit for exactly that cycle; -> WAIT_START.
REQ-021 WAIT_START -> WAIT_DONE when is_transmitting high; -> IDLE after START_TIMEOUT cycles without it; a timed-out byte is lost, not re-sent.
REQ-022 WAIT_DONE -> IDLE when is_transmitting low.
REQ-023 Latency: byte pushed into an empty FIFO with the uart idle SHALL see transmit high 2 cycles after the push edge (push edge, IDLE->LOAD edge).
REQ-024 Bytes SHALL leave in push order; back-to-back bytes have at least one IDLE cycle between them.
REQ-025 transmit SHALL never be asserted outside LOAD.

Reset
REQ-026 rst_n low SHALL immediately clear pointers, level=0, empty=1, full=0, overflow=0, transmit=0, tx_byte=8'h00, state=IDLE; FIFO contents need not clear.
REQ-027 Reset mid-transmission SHALL abandon the byte in flight and all queued bytes; no transmit pulse during or in the first cycle after reset release.
REQ-028 overflow SHALL clear only on reset.

Configuration
REQ-029 Macro UART_TX_FIFO_CRLF_EN: when defined, after a popped 8'h0A completes (WAIT_DONE -> IDLE, or timeout), the block SHALL send 8'h0D via one extra LOAD/WAIT_START/WAIT_DONE pass without popping or changing level, before any further pop.
REQ-030 When UART_TX_FIFO_CRLF_EN is undefined, all bytes SHALL be sent verbatim with no insertion.

Verification
REQ-031 Push "H","i" into empty FIFO, model uart busy 10 cycles per byte -> transmit pulses with tx_byte 8'h48 then 8'h69, level returns 0, empty=1.
REQ-032 Hold is_transmitting high, push 17 bytes with DEPTH=16 -> full=1, level=16, overflow=1, 17th byte never transmitted.
REQ-033 Push 8'h41 with is_transmitting stuck low -> transmit once, IDLE after 15 WAIT_START cycles, no retry, level=0.
REQ-034 Push 3 bytes, assert rst_n low during second byte's WAIT_DONE -> all outputs at reset values immediately, no further transmit pulses after release.
REQ-035 CRLF_EN defined, push 8'h0A,8'h41 -> transmitted sequence 8'h0A,8'h0D,8'h41; undefined -> 8'h0A,8'h41.
REQ-036 Pointer wrap: push/drain 40 bytes through DEPTH=16 in bursts of 10 -> output order equals input order, no overflow.
